ram_arbiter: RTL and testbench

Two-port request/acknowledge arbiter that sits directly upstream of the team's synchronous RAM (`RAM_sync`), letting two masters share one single-port memory. Typical use: CPU on port A, video/DMA fetch on port B. It drives the RAM's address, data-in and write-enable from registered outputs, one access per cycle. It returns the RAM's registered read data to the master that issued the read, flagged with a per-port valid pulse.

---
 rtl/ram_arbiter_pkg.sv | 28 ++
 rtl/ram_sync.sv | 24 ++
 rtl/ram_arbiter.sv | 117 +++++++++++
 tb/tb_ram_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter.
// Port identifiers, the read-return tag and the grant-selection helper.
package ram_arbiter_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } rd_tag_t;

  // Winner among eligible ports; only meaningful when ea | eb.
  function automatic port_e arb_pick(
    input logic  ea,
    input logic  eb,
    input port_e last,
    input logic  fixed
  );
    if (!eb) return PORT_A;
    if (!ea) return PORT_B;
    if (fixed) return PORT_A;
    return (last == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/ram_sync.sv
// Synchronous single-port RAM with registered read data.
// Read-before-write: a write cycle returns the old word.
module RAM_sync #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic [A-1:0] addr,
  input  logic [D-1:0] din,
  input  logic         we,
  output logic [D-1:0] dout
);

  logic [D-1:0] mem [2**A];
  logic [D-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-master request/ack arbiter in front of RAM_sync.
// One access per cycle; read data returned with a per-port valid.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int A          = 10,
  parameter int D          = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         we_a,
  input  logic         we_b,
  input  logic [A-1:0] addr_a,
  input  logic [A-1:0] addr_b,
  input  logic [D-1:0] wdata_a,
  input  logic [D-1:0] wdata_b,
  output logic         ack_a,
  output logic         ack_b,
  output logic         rvalid_a,
  output logic         rvalid_b,
  output logic [D-1:0] rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  logic         ack_a_q, ack_a_d;
  logic         ack_b_q, ack_b_d;
  logic         rvalid_a_q, rvalid_a_d;
  logic         rvalid_b_q, rvalid_b_d;
  logic [A-1:0] ram_addr_q, ram_addr_d;
  logic [D-1:0] ram_din_q, ram_din_d;
  logic         ram_we_q, ram_we_d;
  port_e        last_q, last_d;
  rd_tag_t      tag_q, tag_d;

  logic  elig_a;
  logic  elig_b;
  port_e sel;

  // The ack cycle masks a still-held request.
  assign elig_a = req_a & ~ack_a_q;
  assign elig_b = req_b & ~ack_b_q;
  assign sel    = arb_pick(elig_a, elig_b, last_q,
                           logic'(FIXED_PRIO));

  always_comb begin
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    last_d     = last_q;
    tag_d      = '0;
    rvalid_a_d = tag_q.vld & (tag_q.port == PORT_A);
    rvalid_b_d = tag_q.vld & (tag_q.port == PORT_B);
    if (elig_a | elig_b) begin
      last_d = sel;
      unique case (sel)
        PORT_A: begin
          ack_a_d    = 1'b1;
          ram_addr_d = addr_a;
          ram_din_d  = wdata_a;
          ram_we_d   = we_a;
          tag_d.vld  = ~we_a;
          tag_d.port = PORT_A;
        end
        PORT_B: begin
          ack_b_d    = 1'b1;
          ram_addr_d = addr_b;
          ram_din_d  = wdata_b;
          ram_we_d   = we_b;
          tag_d.vld  = ~we_b;
          tag_d.port = PORT_B;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      last_q     <= PORT_B;
      tag_q      <= '0;
    end else begin
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      last_q     <= last_d;
      tag_q      <= tag_d;
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench: round-robin and fixed-priority arbiters, each on its own RAM,
// driven by one shared vector table with a read-return scoreboard.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_a, req_b, we_a, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;

  logic       ack_a0, ack_b0, rva0, rvb0, we0;
  logic [3:0] ad0;
  logic [7:0] dn0, rd0, dout0;
  logic       ack_a1, ack_b1, rva1, rvb1, we1;
  logic [3:0] ad1;
  logic [7:0] dn1, rd1, dout1;

  always #5 clk = ~clk;

  ram_arbiter #(.A(4), .D(8), .FIXED_PRIO(1'b0)) u_arb0 (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a0), .ack_b(ack_b0),
    .rvalid_a(rva0), .rvalid_b(rvb0), .rdata(rd0),
    .ram_addr(ad0), .ram_din(dn0), .ram_we(we0),
    .ram_dout(dout0)
  );
  RAM_sync #(.A(4), .D(8)) u_ram0 (
    .clk(clk), .addr(ad0), .din(dn0), .we(we0), .dout(dout0)
  );

  ram_arbiter #(.A(4), .D(8), .FIXED_PRIO(1'b1)) u_arb1 (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a1), .ack_b(ack_b1),
    .rvalid_a(rva1), .rvalid_b(rvb1), .rdata(rd1),
    .ram_addr(ad1), .ram_din(dn1), .ram_we(we1),
    .ram_dout(dout1)
  );
  RAM_sync #(.A(4), .D(8)) u_ram1 (
    .clk(clk), .addr(ad1), .din(dn1), .we(we1), .dout(dout1)
  );

  typedef struct {
    logic       rst;
    logic       ra, wa;
    logic [3:0] aa;
    logic [7:0] da;
    logic       rb, wb;
    logic [3:0] ab;
    logic [7:0] db;
    logic [3:0] eak;
  } vec_t;

  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } sb_t;

  vec_t       tbl [31];
  sb_t        sb0 [$];
  sb_t        sb1 [$];
  logic [7:0] shadow [2][16];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t v(
    input logic rst, input logic ra, input logic wa,
    input logic [3:0] aa, input logic [7:0] da,
    input logic rb, input logic wb,
    input logic [3:0] ab, input logic [7:0] db,
    input logic [3:0] eak
  );
    vec_t r;
    r.rst = rst; r.ra = ra; r.wa = wa; r.aa = aa; r.da = da;
    r.rb = rb; r.wb = wb; r.ab = ab; r.db = db; r.eak = eak;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_inst(
    input int inst, input int row, input vec_t t,
    input logic aa_, input logic ab_,
    input logic rva, input logic rvb, input logic we_,
    input logic [3:0] ad, input logic [7:0] dn, input logic [7:0] rd
  );
    sb_t  q [$];
    sb_t  e;
    logic ea, eb, xa, xb;
    string p;
    p = $sformatf("i%0d r%0d", inst, row);
    if (inst == 0) q = sb0; else q = sb1;
    ea = t.eak[3 - 2*inst];
    eb = t.eak[2 - 2*inst];
    if (t.rst) begin
      q.delete();
      chk({p, " ram_addr"}, int'(ad), 0);
      chk({p, " ram_din"}, int'(dn), 0);
    end
    chk({p, " ack_a"}, int'(aa_), int'(ea));
    chk({p, " ack_b"}, int'(ab_), int'(eb));
    chk({p, " ram_we"}, int'(we_), int'((ea & t.wa) | (eb & t.wb)));
    if (ea) chk({p, " ram_addr"}, int'(ad), int'(t.aa));
    if (eb) chk({p, " ram_addr"}, int'(ad), int'(t.ab));
    xa = 1'b0;
    xb = 1'b0;
    if (q.size() > 0 && q[0].due == row) begin
      xa = (q[0].port == 1'b0);
      xb = (q[0].port == 1'b1);
    end
    chk({p, " rvalid_a"}, int'(rva), int'(xa));
    chk({p, " rvalid_b"}, int'(rvb), int'(xb));
    if (xa | xb) begin
      chk({p, " rdata"}, int'(rd), int'(q[0].data));
      void'(q.pop_front());
    end
    if (ea) begin
      if (t.wa) shadow[inst][t.aa] = t.da;
      else begin
        e.due = row + 1; e.port = 1'b0; e.data = shadow[inst][t.aa];
        q.push_back(e);
      end
    end
    if (eb) begin
      if (t.wb) shadow[inst][t.ab] = t.db;
      else begin
        e.due = row + 1; e.port = 1'b1; e.data = shadow[inst][t.ab];
        q.push_back(e);
      end
    end
    if (inst == 0) sb0 = q; else sb1 = q;
  endtask

  initial begin
    int   n0, n1;
    logic p0, p1, dbl0, dbl1;
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    foreach (shadow[i, j]) shadow[i][j] = 8'h00;

    // eak = {ack_a rr, ack_b rr, ack_a fixed, ack_b fixed}
    tbl[0]  = v(1, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b0000);
    tbl[1]  = v(0, 0,0,4'd0,8'h00, 1,1,4'd3,8'h5A, 4'b0101);
    tbl[2]  = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[3]  = v(1, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b0000);
    tbl[4]  = v(0, 1,0,4'd3,8'h00, 0,0,4'd0,8'h00, 4'b1010);
    tbl[5]  = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[6]  = v(0, 0,0,4'd0,8'h00, 1,1,4'd7,8'hC3, 4'b0101);
    tbl[7]  = v(0, 0,0,4'd0,8'h00, 1,0,4'd7,8'h00, 4'b0000);
    tbl[8]  = v(0, 0,0,4'd0,8'h00, 1,0,4'd7,8'h00, 4'b0101);
    tbl[9]  = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[10] = v(0, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b1010);
    tbl[11] = v(0, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b0101);
    tbl[12] = v(0, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b1010);
    tbl[13] = v(0, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b0101);
    tbl[14] = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[15] = v(0, 1,1,4'd5,8'h11, 0,0,4'd0,8'h00, 4'b1010);
    tbl[16] = v(0, 1,0,4'd5,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[17] = v(0, 1,0,4'd5,8'h00, 1,0,4'd3,8'h00, 4'b0110);
    tbl[18] = v(0, 1,0,4'd5,8'h00, 1,0,4'd3,8'h00, 4'b1001);
    tbl[19] = v(0, 1,0,4'd5,8'h00, 1,0,4'd3,8'h00, 4'b0110);
    tbl[20] = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[21] = v(0, 1,0,4'd7,8'h00, 0,0,4'd0,8'h00, 4'b1010);
    tbl[22] = v(0, 1,0,4'd7,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[23] = v(0, 1,0,4'd7,8'h00, 0,0,4'd0,8'h00, 4'b1010);
    tbl[24] = v(0, 1,0,4'd7,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[25] = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);
    tbl[26] = v(0, 1,0,4'd3,8'h00, 0,0,4'd0,8'h00, 4'b1010);
    tbl[27] = v(1, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b0000);
    tbl[28] = v(0, 1,0,4'd3,8'h00, 1,0,4'd7,8'h00, 4'b1010);
    tbl[29] = v(0, 0,0,4'd0,8'h00, 1,0,4'd7,8'h00, 4'b0101);
    tbl[30] = v(0, 0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 4'b0000);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      reset_n = ~tbl[i].rst;
      req_a = tbl[i].ra; we_a = tbl[i].wa;
      addr_a = tbl[i].aa; wdata_a = tbl[i].da;
      req_b = tbl[i].rb; we_b = tbl[i].wb;
      addr_b = tbl[i].ab; wdata_b = tbl[i].db;
      @(posedge clk);
      #1;
      chk_inst(0, i, tbl[i], ack_a0, ack_b0, rva0, rvb0, we0,
               ad0, dn0, rd0);
      chk_inst(1, i, tbl[i], ack_a1, ack_b1, rva1, rvb1, we1,
               ad1, dn1, rd1);
    end
    chk("sb0 drained", sb0.size(), 0);
    chk("sb1 drained", sb1.size(), 0);

    // A holds one read for 8 cycles: every other cycle granted.
    n0 = 0; n1 = 0; p0 = 1'b0; p1 = 1'b0; dbl0 = 1'b0; dbl1 = 1'b0;
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd7; req_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (ack_a0) n0++;
      if (ack_a1) n1++;
      if (ack_a0 && p0) dbl0 = 1'b1;
      if (ack_a1 && p1) dbl1 = 1'b1;
      p0 = ack_a0;
      p1 = ack_a1;
    end
    @(negedge clk);
    req_a = 1'b0;
    chk("hold rr grants", n0, 4);
    chk("hold fx grants", n1, 4);
    chk("hold rr back2back", int'(dbl0), 0);
    chk("hold fx back2back", int'(dbl1), 0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
